// File: rtl/robs_mult_scheduler.sv
// Time-shares one Robertson multiplier among NREQ requesters: round-robin
// grant, operand latching, reset-pulse start, done capture and watchdog abort.
module robs_mult_scheduler #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_multiplier,
    input  logic [NREQ*WIDTH-1:0]   req_multiplicand,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]      rsp_product,
    output logic                    rsp_timeout,
    output logic                    mult_reset,
    output logic [WIDTH-1:0]        mult_multiplier,
    output logic [WIDTH-1:0]        mult_multiplicand,
    input  logic [2*WIDTH-1:0]      mult_product,
    input  logic                    mult_done,
    output logic [1:0]              dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high. req_ready is a combinational one-hot grant that only depends
    // on req_valid and internal state; rsp_valid never depends on rsp_ready
    // and rsp_* hold stable until the transfer.

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_timeout_q, rsp_timeout_d;
    logic [2*WIDTH-1:0] rsp_product_q, rsp_product_d;

    logic               grant_any;
    logic [IDW-1:0]     grant_id;
    logic [IDW-1:0]     cand;
    logic [WIDTH-1:0]   sel_mplier;
    logic [WIDTH-1:0]   sel_mcand;
    logic               run_first;
    logic               run_done;
    logic               run_expire;
    logic               rsp_hs;

    // Scan starts just after the last winner so every holder gets a turn.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
    end

    always_comb begin
        sel_mplier = '0;
        sel_mcand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_mplier = req_multiplier[i*WIDTH +: WIDTH];
                sel_mcand  = req_multiplicand[i*WIDTH +: WIDTH];
            end
        end
    end

    // A done left over from the previous operation is ignored in RUN cycle one.
    assign run_first  = (cnt_q == '0);
    assign run_done   = (state_q == S_RUN) && !run_first && mult_done;
    assign run_expire = (state_q == S_RUN) && !run_done && (cnt_q == CW'(TIMEOUT - 1));
    assign rsp_hs     = rsp_valid_q && rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (grant_any) state_d = S_START;
            S_START: state_d = S_RUN;
            S_RUN:   if (run_done || run_expire) state_d = S_RESP;
            S_RESP:  if (rsp_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        if (state_q == S_IDLE && grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
        mult_reset = (state_q != S_RUN);
    end

    always_comb begin
        ptr_d         = ptr_q;
        id_d          = id_q;
        mplier_d      = mplier_q;
        mcand_d       = mcand_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_product_d = rsp_product_q;
        if (state_q == S_IDLE && grant_any) begin
            ptr_d    = grant_id;
            id_d     = grant_id;
            mplier_d = sel_mplier;
            mcand_d  = sel_mcand;
        end
        if (state_q == S_START) begin
            cnt_d = '0;
        end
        if (state_q == S_RUN) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (run_done) begin
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_product_d = mult_product;
        end else if (run_expire) begin
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_product_d = '0;
        end
        if (state_q == S_RESP && rsp_hs) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q         <= IDW'(NREQ - 1);
            id_q          <= '0;
            mplier_q      <= '0;
            mcand_q       <= '0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_product_q <= '0;
        end else begin
            ptr_q         <= ptr_d;
            id_q          <= id_d;
            mplier_q      <= mplier_d;
            mcand_q       <= mcand_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_product_q <= rsp_product_d;
        end
    end

    assign rsp_valid         = rsp_valid_q;
    assign rsp_id            = id_q;
    assign rsp_product       = rsp_product_q;
    assign rsp_timeout       = rsp_timeout_q;
    assign mult_multiplier   = mplier_q;
    assign mult_multiplicand = mcand_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_robs_mult_scheduler.sv
// Directed plus randomized checks of robs_mult_scheduler against a round-robin
// and signed-product reference, with a behavioural multiplier stub.
module tb_robs_mult_scheduler;

    localparam int WIDTH   = 8;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int IDW     = $clog2(NREQ);
    localparam int PW      = 2 * WIDTH;
    localparam logic [PW-1:0] STALE = 16'hDEAD;

    localparam int OP_HOLD  = 0;
    localparam int OP_DROP  = 1;
    localparam int OP_CHURN = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_multiplier;
    logic [NREQ*WIDTH-1:0] req_multiplicand;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [PW-1:0]         rsp_product;
    logic                  rsp_timeout;
    logic                  mult_reset;
    logic [WIDTH-1:0]      mult_multiplier;
    logic [WIDTH-1:0]      mult_multiplicand;
    logic [PW-1:0]         mult_product;
    logic                  mult_done;
    logic [1:0]            dbg_state;

    logic [WIDTH-1:0] op_a [NREQ];
    logic [WIDTH-1:0] op_b [NREQ];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int            rr_ptr;
    int            waits [NREQ];
    logic [PW-1:0] exp_q [$];
    int            exp_id_q [$];
    int            last_gid;
    logic [PW-1:0] last_prod;

    // multiplier stub: 0 = done after stub_lat cycles, 1 = never done, 2 = done always
    int stub_mode = 0;
    int stub_lat  = 3;
    int run_cnt   = 0;

    robs_mult_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_multiplier    (req_multiplier),
        .req_multiplicand  (req_multiplicand),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_id            (rsp_id),
        .rsp_product       (rsp_product),
        .rsp_timeout       (rsp_timeout),
        .mult_reset        (mult_reset),
        .mult_multiplier   (mult_multiplier),
        .mult_multiplicand (mult_multiplicand),
        .mult_product      (mult_product),
        .mult_done         (mult_done),
        .dbg_state_o       (dbg_state)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_multiplier[i*WIDTH +: WIDTH]   = op_a[i];
            req_multiplicand[i*WIDTH +: WIDTH] = op_b[i];
        end
    end

    function automatic logic [PW-1:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int sx;
        int sy;
        sx = $signed(x);
        sy = $signed(y);
        return PW'(sx * sy);
    endfunction

    always @(posedge clk) begin
        if (mult_reset) run_cnt <= 0;
        else            run_cnt <= run_cnt + 1;
    end

    assign mult_done = (stub_mode == 1) ? 1'b0 :
                       (stub_mode == 2) ? 1'b1 :
                       (!mult_reset && run_cnt >= stub_lat);
    assign mult_product = (stub_mode == 2) ?
                              ((mult_reset || run_cnt == 0) ? STALE : ref_mul(mult_multiplier, mult_multiplicand)) :
                              (mult_done ? ref_mul(mult_multiplier, mult_multiplicand) : STALE);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] m);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(rr_ptr + k) % NREQ]) return (rr_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        rr_ptr = NREQ - 1;
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
        exp_q.delete();
        exp_id_q.delete();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Called just after a negedge; returns just after the negedge following the response handshake.
    task automatic serve_one(input int bp_cycles, input int mode);
        bit            got;
        int            gid;
        int            runs;
        int            exp_runs;
        int            eid;
        bit            is_to;
        logic [PW-1:0] exp_p;
        logic [WIDTH-1:0] a0;
        logic [WIDTH-1:0] b0;
        logic [PW-1:0] h_prod;
        logic [IDW-1:0] h_id;
        logic          h_to;

        #1;
        got = 0;
        for (int t = 0; t < 20; t++) begin
            if (req_ready != '0) begin
                got = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check("grant_seen", 32'(got), 32'd1);
        if (!got) return;

        gid = model_pick(req_valid);
        check("grant_onehot", 32'(req_ready), 32'(1) << gid);
        check("starve_bound", 32'(waits[gid] <= NREQ - 1), 32'd1);
        for (int i = 0; i < NREQ; i++) begin
            if (i == gid)          waits[i] = 0;
            else if (req_valid[i]) waits[i] = waits[i] + 1;
        end
        rr_ptr   = gid;
        last_gid = gid;
        a0       = op_a[gid];
        b0       = op_b[gid];
        exp_q.push_back(ref_mul(a0, b0));
        exp_id_q.push_back(gid);
        is_to = (stub_mode == 1);
        if (stub_mode == 1)      exp_runs = TIMEOUT;
        else if (stub_mode == 2) exp_runs = 2;
        else                     exp_runs = ((stub_lat < 1) ? 1 : stub_lat) + 1;
        if (exp_runs > TIMEOUT) exp_runs = TIMEOUT;

        @(negedge clk);
        #1;
        check("start_mreset", 32'(mult_reset), 32'd1);
        check("start_mplier", 32'(mult_multiplier), 32'(a0));
        check("start_mcand", 32'(mult_multiplicand), 32'(b0));
        check("start_noready", 32'(req_ready), 32'd0);
        if (bp_cycles > 0) rsp_ready = 1'b0;
        if (mode == OP_DROP) begin
            req_valid[gid] = 1'b0;
        end else if (mode == OP_CHURN) begin
            if ($urandom_range(1, 0) == 1) req_valid[gid] = 1'b0;
            op_a[gid] = WIDTH'($urandom);
            op_b[gid] = WIDTH'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && i != gid && $urandom_range(2, 0) == 0) begin
                    op_a[i]      = WIDTH'($urandom);
                    op_b[i]      = WIDTH'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
        end

        got  = 0;
        runs = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) begin
                got = 1;
                break;
            end
            if (runs == 0) begin
                check("run_mreset", 32'(mult_reset), 32'd0);
                check("run_mplier_held", 32'(mult_multiplier), 32'(a0));
                check("run_mcand_held", 32'(mult_multiplicand), 32'(b0));
            end
            runs++;
        end
        check("rsp_seen", 32'(got), 32'd1);
        if (!got) return;

        exp_p = exp_q.pop_front();
        eid   = exp_id_q.pop_front();
        check("rsp_latency", 32'(runs), 32'(exp_runs));
        check("rsp_id", 32'(rsp_id), 32'(eid));
        check("rsp_timeout", 32'(rsp_timeout), 32'(is_to));
        check("rsp_product", 32'(rsp_product), is_to ? 32'd0 : 32'(exp_p));
        check("resp_mreset", 32'(mult_reset), 32'd1);
        last_prod = rsp_product;
        h_prod    = rsp_product;
        h_id      = rsp_id;
        h_to      = rsp_timeout;

        for (int c = 0; c < bp_cycles; c++) begin
            @(negedge clk);
            #1;
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_product", 32'(rsp_product), 32'(h_prod));
            check("bp_id", 32'(rsp_id), 32'(h_id));
            check("bp_timeout", 32'(rsp_timeout), 32'(h_to));
            check("bp_noready", 32'(req_ready), 32'd0);
            check("bp_mreset", 32'(mult_reset), 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("hs_clear", 32'(rsp_valid), 32'd0);
        check("idle_after_hs", 32'(req_ready != '0), 32'(req_valid != '0));
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        bit saw_rsp;
        bit got;

        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_product", 32'(rsp_product), 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("rst_mult_reset", 32'(mult_reset), 32'd1);
        check("rst_mplier", 32'(mult_multiplier), 32'd0);
        check("rst_mcand", 32'(mult_multiplicand), 32'd0);

        // single request, 7 * -3
        @(negedge clk);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        stub_mode = 0;
        stub_lat  = 3;
        op_a[0]   = 8'd7;
        op_b[0]   = 8'hFD;
        req_valid = 4'b0001;
        serve_one(0, OP_DROP);
        check("t1_gid", 32'(last_gid), 32'd0);
        check("t1_product", 32'(last_prod), 32'h0000FFEB);

        // round robin with all requesters held
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = WIDTH'(8'h11 * (i + 1));
            op_b[i] = WIDTH'(8'hF0 - 8'h13 * i);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            stub_lat = 2 + k;
            serve_one(0, OP_HOLD);
            check("t2_order", 32'(last_gid), 32'(exp_order[k]));
        end

        // response backpressure for 10 cycles
        serve_one(10, OP_HOLD);

        // watchdog: multiplier never finishes
        req_valid = '0;
        stub_mode = 1;
        op_a[1]   = 8'h55;
        op_b[1]   = 8'h81;
        req_valid = 4'b0010;
        serve_one(0, OP_DROP);

        // stale done held high
        stub_mode = 2;
        op_a[3]   = 8'h80;
        op_b[3]   = 8'h80;
        req_valid = 4'b1000;
        serve_one(0, OP_DROP);

        // reset in the middle of RUN
        stub_mode = 0;
        stub_lat  = 5;
        op_a[2]   = 8'h12;
        op_b[2]   = 8'h34;
        req_valid = 4'b0100;
        #1;
        got = 0;
        for (int t = 0; t < 20; t++) begin
            if (req_ready != '0) begin
                got = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check("t6_grant", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("t6_rst_mreset", 32'(mult_reset), 32'd1);
        check("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        model_reset();
        saw_rsp = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) saw_rsp = 1;
        end
        check("t6_discarded", 32'(saw_rsp), 32'd0);
        check("t6_idle_mreset", 32'(mult_reset), 32'd1);
        op_a[1]   = 8'hF9;
        op_b[1]   = 8'h09;
        op_a[3]   = 8'h03;
        op_b[3]   = 8'h04;
        req_valid = 4'b1010;
        #1;
        check("t6_ptr_reset", 32'(req_ready), 32'b0010);
        serve_one(0, OP_DROP);
        check("t6_first_gid", 32'(last_gid), 32'd1);
        serve_one(0, OP_DROP);
        check("t6_second_gid", 32'(last_gid), 32'd3);

        // randomized traffic
        for (int n = 0; n < 30; n++) begin
            stub_lat = $urandom_range(10, 1);
            if (req_valid == '0) begin
                req_valid = NREQ'($urandom_range((1 << NREQ) - 1, 1));
                for (int i = 0; i < NREQ; i++) begin
                    op_a[i] = WIDTH'($urandom);
                    op_b[i] = WIDTH'($urandom);
                end
            end
            serve_one($urandom_range(3, 0), OP_CHURN);
        end

        req_valid = '0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no end of test, expected finish before 500000");
        $fatal(1, "bench did not finish");
    end

endmodule
